div_sc_mem_resp: RTL and testbench

- Scratch-memory responder on the far side of the divider's scratch-memory interface.
- Serves the divider's two 128-bit read ports (4 x 32-bit CDF lanes per word) and its single write port.
- Tracks the divider's rd_done/wt_done completion handshake.
- Provides a load port so the CDF stage can fill the memory before the divider is enabled.

---
 rtl/div_sc_mem_pkg.sv | 7 +
 rtl/sc_mem_2r1w.sv | 33 +++
 rtl/div_sc_mem_resp.sv | 100 ++++++++++
 tb/tb_div_sc_mem_resp.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/div_sc_mem_pkg.sv
// div_sc_mem_pkg: shared widths and FSM encoding for the divider scratch-memory responder
package div_sc_mem_pkg;
  localparam int DATA_W = 128;
  localparam int LANE_W = 32;
  localparam int ADDR_W = 16;
  typedef enum logic [1:0] {IDLE = 2'b00, ACTIVE = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/sc_mem_2r1w.sv
// sc_mem_2r1w: DEPTH x 128 array, two registered read ports, one write port with write-first bypass
module sc_mem_2r1w
  import div_sc_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_byp,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr1,
  input  logic [AW-1:0]     i_raddr2,
  input  logic              i_rok1,
  input  logic              i_rok2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  // i_byp is separate from i_we so that loads never forward to the read outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_rdata1 <= '0;
      o_rdata2 <= '0;
    end else begin
      o_rdata1 <= !i_rok1 ? '0 : (i_byp && i_waddr == i_raddr1) ? i_wdata : r_mem[i_raddr1];
      o_rdata2 <= !i_rok2 ? '0 : (i_byp && i_waddr == i_raddr2) ? i_wdata : r_mem[i_raddr2];
    end
endmodule

// File: rtl/div_sc_mem_resp.sv
// div_sc_mem_resp: scratch-memory responder serving the divider's read/write ports and the CDF load port
module div_sc_mem_resp
  import div_sc_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] div_sc_mem_rd_addr1,
  input  logic [ADDR_W-1:0] div_sc_mem_rd_addr2,
  output logic [DATA_W-1:0] div_sc_mem_rd_data1,
  output logic [DATA_W-1:0] div_sc_mem_rd_data2,
  input  logic [ADDR_W-1:0] div_sc_mem_wt_addr,
  input  logic [DATA_W-1:0] div_sc_mem_wt_data,
  input  logic              div_sc_mem_wt_en,
  input  logic              div_sc_mem_rd_done,
  input  logic              div_sc_mem_wt_done,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_reject,
  output logic              busy,
  output logic              all_done,
  output logic [ADDR_W-1:0] wr_count,
  output logic              addr_err
);
  state_t r_state;
  logic r_en_q, r_rd_done, r_wt_done;
  logic w_rd_ok1, w_rd_ok2, w_wt_ok, w_ld_ok, w_dw, w_lw, w_err;
  assign w_rd_ok1 = (div_sc_mem_rd_addr1 >> AW) == '0;
  assign w_rd_ok2 = (div_sc_mem_rd_addr2 >> AW) == '0;
  assign w_wt_ok  = (div_sc_mem_wt_addr >> AW) == '0;
  assign w_ld_ok  = (ld_addr >> AW) == '0;
  assign w_dw     = r_state == ACTIVE && div_sc_mem_wt_en && w_wt_ok;
  assign w_lw     = r_state == IDLE && ld_en && w_ld_ok;
  assign w_err    = !w_rd_ok1 || !w_rd_ok2 || (r_state == ACTIVE && div_sc_mem_wt_en && !w_wt_ok) ||
                    (r_state == IDLE && ld_en && !w_ld_ok);
  sc_mem_2r1w #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk      (clk),
    .rst      (reset),
    .i_we     (w_dw || w_lw),
    .i_byp    (w_dw),
    .i_waddr  (w_dw ? div_sc_mem_wt_addr[AW-1:0] : ld_addr[AW-1:0]),
    .i_wdata  (w_dw ? div_sc_mem_wt_data : ld_data),
    .i_raddr1 (div_sc_mem_rd_addr1[AW-1:0]),
    .i_raddr2 (div_sc_mem_rd_addr2[AW-1:0]),
    .i_rok1   (w_rd_ok1),
    .i_rok2   (w_rd_ok2),
    .o_rdata1 (div_sc_mem_rd_data1),
    .o_rdata2 (div_sc_mem_rd_data2)
  );
  // r_en_q resets high so an enable held across reset cannot start a pass
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= IDLE;
      r_en_q    <= 1'b1;
      r_rd_done <= 1'b0;
      r_wt_done <= 1'b0;
      busy      <= 1'b0;
      all_done  <= 1'b0;
      wr_count  <= '0;
      ld_reject <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      r_en_q    <= enable;
      ld_reject <= ld_en && r_state != IDLE;
      addr_err  <= addr_err || w_err;
      if (w_dw && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      case (r_state)
        IDLE:
          if (enable && !r_en_q) begin
            r_state   <= ACTIVE;
            busy      <= 1'b1;
            wr_count  <= '0;
            r_rd_done <= 1'b0;
            r_wt_done <= 1'b0;
          end
        ACTIVE: begin
          r_rd_done <= r_rd_done || div_sc_mem_rd_done;
          r_wt_done <= r_wt_done || div_sc_mem_wt_done;
          if (!enable) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else if (r_rd_done && r_wt_done) begin
            r_state  <= DONE;
            busy     <= 1'b0;
            all_done <= 1'b1;
          end
        end
        DONE:
          if (!enable) begin
            r_state  <= IDLE;
            all_done <= 1'b0;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_div_sc_mem_resp.sv
// tb_div_sc_mem_resp: directed self-checking bench for div_sc_mem_resp
module tb_div_sc_mem_resp;
  logic clk = 0, reset = 1, enable = 0;
  logic [15:0] rd_addr1 = 0, rd_addr2 = 0, wt_addr = 0, ld_addr = 0;
  logic [127:0] rd_data1, rd_data2, wt_data = 0, ld_data = 0;
  logic wt_en = 0, rd_done = 0, wt_done = 0, ld_en = 0;
  logic ld_reject, busy, all_done, addr_err;
  logic [15:0] wr_count;
  int checks = 0, failures = 0;
  localparam logic [127:0] W0 = {4{32'h00000961}};
  localparam logic [127:0] W1 = {4{32'h000012C1}};
  localparam logic [127:0] A5 = {16{8'hA5}};

  div_sc_mem_resp #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .div_sc_mem_rd_addr1(rd_addr1), .div_sc_mem_rd_addr2(rd_addr2),
    .div_sc_mem_rd_data1(rd_data1), .div_sc_mem_rd_data2(rd_data2),
    .div_sc_mem_wt_addr(wt_addr), .div_sc_mem_wt_data(wt_data), .div_sc_mem_wt_en(wt_en),
    .div_sc_mem_rd_done(rd_done), .div_sc_mem_wt_done(wt_done),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_reject(ld_reject),
    .busy(busy), .all_done(all_done), .wr_count(wr_count), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] dw(int i);
    return {96'h0, 32'hD000_0000 + 32'(i)};
  endfunction

  task automatic test_reset;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (all_done !== 1'b0) begin failures++; $display("FAIL rst_all_done got=%0b exp=0", all_done); end
    checks++; if (wr_count !== 16'h0) begin failures++; $display("FAIL rst_wr_count got=%h exp=0", wr_count); end
    checks++; if (addr_err !== 1'b0 || ld_reject !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", addr_err, ld_reject); end
    checks++; if (rd_data1 !== '0 || rd_data2 !== '0) begin failures++; $display("FAIL rst_rd_data got=%h/%h exp=0", rd_data1, rd_data2); end
    tick; tick;
    reset = 0;
    tick;
  endtask

  task automatic test_load_read;
    ld_en = 1; ld_addr = 0; ld_data = W0; tick;
    ld_addr = 1; ld_data = W1; tick;
    ld_en = 0; rd_addr1 = 0; rd_addr2 = 1; tick;
    checks++; if (rd_data1 !== W0) begin failures++; $display("FAIL load_rd1 got=%h exp=%h", rd_data1, W0); end
    checks++; if (rd_data2 !== W1) begin failures++; $display("FAIL load_rd2 got=%h exp=%h", rd_data2, W1); end
    checks++; if (addr_err !== 1'b0 || ld_reject !== 1'b0) begin failures++; $display("FAIL load_flags got=%b%b exp=00", addr_err, ld_reject); end
  endtask

  task automatic test_pass;
    enable = 1; tick;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pass_busy got=%0b exp=1", busy); end
    for (int i = 0; i < 4; i++) begin
      wt_en = 1; wt_addr = 16'(2 + i); wt_data = dw(i); tick;
    end
    wt_en = 0; rd_addr1 = 2; tick;
    checks++; if (wr_count !== 16'd4) begin failures++; $display("FAIL pass_wr_count got=%0d exp=4", wr_count); end
    checks++; if (rd_data1 !== dw(0)) begin failures++; $display("FAIL pass_readback got=%h exp=%h", rd_data1, dw(0)); end
    rd_done = 1; tick; rd_done = 0; tick; tick;
    wt_done = 1; tick; wt_done = 0;
    checks++; if (busy !== 1'b1 || all_done !== 1'b0) begin failures++; $display("FAIL pass_pre_done got=%b%b exp=10", busy, all_done); end
    tick;
    checks++; if (busy !== 1'b0 || all_done !== 1'b1) begin failures++; $display("FAIL pass_done got=%b%b exp=01", busy, all_done); end
    enable = 0; tick;
    checks++; if (busy !== 1'b0 || all_done !== 1'b0) begin failures++; $display("FAIL pass_idle got=%b%b exp=00", busy, all_done); end
  endtask

  task automatic test_bypass;
    enable = 1; tick;
    wt_en = 1; wt_addr = 3; wt_data = A5; rd_addr1 = 3; rd_addr2 = 4; tick;
    wt_en = 0;
    checks++; if (rd_data1 !== A5) begin failures++; $display("FAIL byp_rd1 got=%h exp=%h", rd_data1, A5); end
    checks++; if (rd_data2 !== dw(2)) begin failures++; $display("FAIL byp_rd2 got=%h exp=%h", rd_data2, dw(2)); end
    tick;
    checks++; if (rd_data1 !== A5 || wr_count !== 16'd1) begin failures++; $display("FAIL byp_stored got=%h cnt=%0d exp=%h cnt=1", rd_data1, wr_count, A5); end
  endtask

  task automatic test_reject;
    rd_addr1 = 0; ld_en = 1; ld_addr = 0; ld_data = '1; tick;
    ld_en = 0;
    checks++; if (ld_reject !== 1'b1) begin failures++; $display("FAIL rej_pulse got=%0b exp=1", ld_reject); end
    tick;
    checks++; if (ld_reject !== 1'b0) begin failures++; $display("FAIL rej_clear got=%0b exp=0", ld_reject); end
    checks++; if (rd_data1 !== W0) begin failures++; $display("FAIL rej_unchanged got=%h exp=%h", rd_data1, W0); end
    enable = 0; tick;
    checks++; if (busy !== 1'b0 || wr_count !== 16'd1) begin failures++; $display("FAIL early_drop got=%b cnt=%0d exp=0 cnt=1", busy, wr_count); end
  endtask

  task automatic test_range_simul;
    rd_addr1 = 16'h0040; tick;
    checks++; if (rd_data1 !== '0 || addr_err !== 1'b1) begin failures++; $display("FAIL range_rd got=%h err=%b exp=0 err=1", rd_data1, addr_err); end
    rd_addr1 = 0; tick;
    checks++; if (addr_err !== 1'b1 || rd_data1 !== W0) begin failures++; $display("FAIL range_sticky got=%b %h exp=1 %h", addr_err, rd_data1, W0); end
    enable = 1; tick;
    wt_en = 1; wt_addr = 16'h0100; wt_data = '1; tick;
    wt_en = 0;
    checks++; if (wr_count !== 16'd0) begin failures++; $display("FAIL range_wr_drop got=%0d exp=0", wr_count); end
    rd_done = 1; wt_done = 1; tick;
    rd_done = 0; wt_done = 0; tick;
    checks++; if (all_done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL simul_done got=%b%b exp=01", all_done, busy); end
    enable = 0; tick;
  endtask

  task automatic test_mid_reset;
    enable = 1; tick;
    for (int i = 0; i < 7; i++) begin
      wt_en = 1; wt_addr = 16'(6 + i); wt_data = dw(10 + i); tick;
    end
    wt_en = 0;
    checks++; if (wr_count !== 16'd7 || busy !== 1'b1) begin failures++; $display("FAIL mid_pre cnt=%0d busy=%b exp cnt=7 busy=1", wr_count, busy); end
    #2 reset = 1;
    #1;
    checks++; if (busy !== 1'b0 || wr_count !== 16'd0 || addr_err !== 1'b0) begin failures++; $display("FAIL mid_async busy=%b cnt=%0d err=%b exp 0 0 0", busy, wr_count, addr_err); end
    tick;
    reset = 0; tick; tick;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_no_reenter got=%0b exp=0", busy); end
    enable = 0; tick;
    enable = 1; tick;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_reenter got=%0b exp=1", busy); end
    enable = 0; tick;
  endtask

  initial begin
    test_reset;
    test_load_read;
    test_pass;
    test_bypass;
    test_reject;
    test_range_simul;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
